// File: rtl/thiele_coproc_arbiter.sv
// Round-robin arbiter sharing one coprocessor port between the logic-engine and
// Python channels, with a response timeout that returns an error word on a stall.
module thiele_coproc_arbiter #(
    parameter int unsigned TIMEOUT  = 64,
    parameter logic [31:0] ERR_DATA = 32'hDEADBEEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        logic_req,
    input  logic [31:0] logic_addr,
    output logic        logic_ack,
    output logic [31:0] logic_data,
    input  logic        py_req,
    input  logic [31:0] py_code_addr,
    output logic        py_ack,
    output logic [31:0] py_result,
    output logic        cop_req,
    output logic        cop_sel,
    output logic [31:0] cop_addr,
    input  logic        cop_ack,
    input  logic [31:0] cop_data,
    output logic        busy,
    output logic        timeout_err,
    output logic [7:0]  timeout_count,
    input  logic        err_clr
);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_RESPOND   = 2'd2,
        ST_WAIT_DROP = 2'd3
    } state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
    localparam logic        SEL_PY   = 1'b1;

    state_t      state_r;
    state_t      state_nxt_s;
    logic [15:0] timer_r;
    logic        last_grant_r;
    logic        grant_s;
    logic        win_py_s;
    logic        done_s;
    logic        timeout_s;
    logic        owner_req_s;

    logic        cop_req_r;
    logic        cop_sel_r;
    logic [31:0] cop_addr_r;
    logic        logic_ack_r;
    logic [31:0] logic_data_r;
    logic        py_ack_r;
    logic [31:0] py_result_r;
    logic        busy_r;
    logic        timeout_err_r;
    logic [7:0]  timeout_count_r;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        if (v == 8'hFF) begin
            sat_inc8 = 8'hFF;
        end else begin
            sat_inc8 = v + 8'd1;
        end
    endfunction

    // Next-state logic and single-cycle event strobes for the datapath.
    always_comb begin
        state_nxt_s = state_r;
        grant_s     = 1'b0;
        win_py_s    = 1'b0;
        done_s      = 1'b0;
        timeout_s   = 1'b0;
        owner_req_s = cop_sel_r ? py_req : logic_req;
        case (state_r)
            ST_IDLE: begin
                if (logic_req || py_req) begin
                    grant_s     = 1'b1;
                    // On a tie the channel that was not granted last wins.
                    win_py_s    = py_req & (~logic_req | (last_grant_r != SEL_PY));
                    state_nxt_s = ST_ISSUE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (cop_ack) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_RESPOND;
                end else if (timer_r == TMO_LAST) begin
                    done_s      = 1'b1;
                    timeout_s   = 1'b1;
                    state_nxt_s = ST_RESPOND;
                end else begin
                    state_nxt_s = ST_ISSUE;
                end
            end
            ST_RESPOND: begin
                state_nxt_s = ST_WAIT_DROP;
            end
            ST_WAIT_DROP: begin
                if (!owner_req_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_DROP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State register, busy flag and round-robin history.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            busy_r       <= 1'b0;
            last_grant_r <= SEL_PY;
        end else begin
            state_r <= state_nxt_s;
            busy_r  <= (state_nxt_s != ST_IDLE);
            if (state_r == ST_RESPOND) begin
                last_grant_r <= cop_sel_r;
            end
        end
    end

    // Coprocessor request side: grant latch, request level and response timer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cop_req_r  <= 1'b0;
            cop_sel_r  <= 1'b0;
            cop_addr_r <= 32'd0;
            timer_r    <= 16'd0;
        end else begin
            if (grant_s) begin
                cop_req_r  <= 1'b1;
                cop_sel_r  <= win_py_s;
                cop_addr_r <= win_py_s ? py_code_addr : logic_addr;
                timer_r    <= 16'd0;
            end else if (done_s) begin
                cop_req_r <= 1'b0;
            end else if (state_r == ST_ISSUE) begin
                timer_r <= timer_r + 16'd1;
            end
        end
    end

    // Response side: per-channel ack pulse and held result word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            logic_ack_r  <= 1'b0;
            logic_data_r <= 32'd0;
            py_ack_r     <= 1'b0;
            py_result_r  <= 32'd0;
        end else begin
            logic_ack_r <= done_s & ~cop_sel_r;
            py_ack_r    <= done_s & cop_sel_r;
            if (done_s && !cop_sel_r) begin
                logic_data_r <= timeout_s ? ERR_DATA : cop_data;
            end
            if (done_s && cop_sel_r) begin
                py_result_r <= timeout_s ? ERR_DATA : cop_data;
            end
        end
    end

    // Sticky timeout flag and saturating counter; a coincident timeout beats err_clr.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            timeout_err_r   <= 1'b0;
            timeout_count_r <= 8'd0;
        end else begin
            if (timeout_s) begin
                timeout_err_r   <= 1'b1;
                timeout_count_r <= err_clr ? 8'd1 : sat_inc8(timeout_count_r);
            end else if (err_clr) begin
                timeout_err_r   <= 1'b0;
                timeout_count_r <= 8'd0;
            end
        end
    end

    assign cop_req       = cop_req_r;
    assign cop_sel       = cop_sel_r;
    assign cop_addr      = cop_addr_r;
    assign logic_ack     = logic_ack_r;
    assign logic_data    = logic_data_r;
    assign py_ack        = py_ack_r;
    assign py_result     = py_result_r;
    assign busy          = busy_r;
    assign timeout_err   = timeout_err_r;
    assign timeout_count = timeout_count_r;

endmodule

// File: tb/tb_thiele_coproc_arbiter.sv
// Directed self-checking bench for thiele_coproc_arbiter with TIMEOUT=8.
module tb_thiele_coproc_arbiter;

    logic        clk;
    logic        rst_n;
    logic        logic_req;
    logic [31:0] logic_addr;
    logic        logic_ack;
    logic [31:0] logic_data;
    logic        py_req;
    logic [31:0] py_code_addr;
    logic        py_ack;
    logic [31:0] py_result;
    logic        cop_req;
    logic        cop_sel;
    logic [31:0] cop_addr;
    logic        cop_ack;
    logic [31:0] cop_data;
    logic        busy;
    logic        timeout_err;
    logic [7:0]  timeout_count;
    logic        err_clr;

    int n_vec    = 0;
    int n_err    = 0;
    int lack_cnt = 0;
    int pack_cnt = 0;

    thiele_coproc_arbiter #(
        .TIMEOUT  (8),
        .ERR_DATA (32'hDEADBEEF)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .logic_req     (logic_req),
        .logic_addr    (logic_addr),
        .logic_ack     (logic_ack),
        .logic_data    (logic_data),
        .py_req        (py_req),
        .py_code_addr  (py_code_addr),
        .py_ack        (py_ack),
        .py_result     (py_result),
        .cop_req       (cop_req),
        .cop_sel       (cop_sel),
        .cop_addr      (cop_addr),
        .cop_ack       (cop_ack),
        .cop_data      (cop_data),
        .busy          (busy),
        .timeout_err   (timeout_err),
        .timeout_count (timeout_count),
        .err_clr       (err_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Ack pulse counters, sampled on the edge that ends each ack cycle.
    always @(posedge clk) begin
        if (logic_ack) lack_cnt++;
        if (py_ack)    pack_cnt++;
    end

    task automatic check1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_zero(input string tag);
        check1 ({tag, "_cop_req"},   cop_req,     1'b0);
        check1 ({tag, "_cop_sel"},   cop_sel,     1'b0);
        check32({tag, "_cop_addr"},  cop_addr,    32'd0);
        check1 ({tag, "_logic_ack"}, logic_ack,   1'b0);
        check32({tag, "_logic_data"}, logic_data, 32'd0);
        check1 ({tag, "_py_ack"},    py_ack,      1'b0);
        check32({tag, "_py_result"}, py_result,   32'd0);
        check1 ({tag, "_busy"},      busy,        1'b0);
        check1 ({tag, "_tmo_err"},   timeout_err, 1'b0);
        check32({tag, "_tmo_cnt"},   {24'd0, timeout_count}, 32'd0);
    endtask

    task automatic idle_wait(input string tag);
        int k;
        k = 0;
        while (busy && k < 20) begin
            @(negedge clk);
            k++;
        end
        check1(tag, busy, 1'b0);
    endtask

    task automatic wait_cop_req(input string tag);
        int k;
        k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!cop_req && k < 20);
        check1(tag, cop_req, 1'b1);
    endtask

    task automatic do_reset();
        rst_n     = 1'b0;
        logic_req = 1'b0;
        py_req    = 1'b0;
        cop_ack   = 1'b0;
        err_clr   = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Python request that runs into the timeout, optionally with err_clr on the timeout edge.
    task automatic run_timeout(input string tag, input logic clr);
        py_code_addr = 32'h0000_0600;
        py_req = 1'b1;
        repeat (8) @(negedge clk);
        check1({tag, "_req_last"}, cop_req, 1'b1);
        err_clr = clr;
        @(negedge clk);
        err_clr = 1'b0;
        check1 ({tag, "_ack"}, py_ack, 1'b1);
        check32({tag, "_res"}, py_result, 32'hDEADBEEF);
        py_req = 1'b0;
        idle_wait({tag, "_idle"});
    endtask

    initial begin
        int l0;
        int p0;
        int cnt;
        int k;

        rst_n = 1'b0; logic_req = 1'b0; py_req = 1'b0; cop_ack = 1'b0; err_clr = 1'b0;
        logic_addr = 32'd0; py_code_addr = 32'd0; cop_data = 32'd0;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);
        check1("idle_busy", busy, 1'b0);

        // Logic-only request, ack in the third ISSUE cycle
        logic_addr = 32'h0000_0040;
        logic_req  = 1'b1;
        @(negedge clk);
        check1 ("t1_req",  cop_req, 1'b1);
        check1 ("t1_sel",  cop_sel, 1'b0);
        check32("t1_addr", cop_addr, 32'h0000_0040);
        check1 ("t1_busy", busy, 1'b1);
        logic_addr = 32'h0000_0099;
        @(negedge clk);
        check32("t1_addr_hold", cop_addr, 32'h0000_0040);
        @(negedge clk);
        check1("t1_req_3", cop_req, 1'b1);
        cop_ack  = 1'b1;
        cop_data = 32'hABCD1234;
        @(negedge clk);
        check1 ("t1_req_drop", cop_req, 1'b0);
        check1 ("t1_lack",     logic_ack, 1'b1);
        check32("t1_ldata",    logic_data, 32'hABCD1234);
        check1 ("t1_pack",     py_ack, 1'b0);
        cop_data  = 32'h0BAD_F00D;
        logic_req = 1'b0;
        @(negedge clk);
        check1 ("t1_lack_one", logic_ack, 1'b0);
        check32("t1_ldata_ign", logic_data, 32'hABCD1234);
        @(negedge clk);
        check1 ("t1_idle", busy, 1'b0);
        cop_ack = 1'b0;
        @(negedge clk);
        check32("t1_ldata_hold", logic_data, 32'hABCD1234);
        check32("t1_lack_cnt", 32'(lack_cnt), 32'd1);
        check32("t1_pack_cnt", 32'(pack_cnt), 32'd0);

        // Simultaneous requests out of reset: logic first, then Python
        do_reset();
        l0 = lack_cnt; p0 = pack_cnt;
        logic_addr = 32'h0000_0100; py_code_addr = 32'h0000_0200;
        logic_req = 1'b1; py_req = 1'b1;
        @(negedge clk);
        check1 ("t2_sel_l",  cop_sel, 1'b0);
        check32("t2_addr_l", cop_addr, 32'h0000_0100);
        cop_ack = 1'b1; cop_data = 32'h1111_1111;
        @(negedge clk);
        check1 ("t2_lack",  logic_ack, 1'b1);
        check1 ("t2_pack0", py_ack, 1'b0);
        check32("t2_ldata", logic_data, 32'h1111_1111);
        cop_ack = 1'b0; logic_req = 1'b0;
        repeat (2) @(negedge clk);
        check1("t2_gap_req", cop_req, 1'b0);
        @(negedge clk);
        check1 ("t2_req_p",  cop_req, 1'b1);
        check1 ("t2_sel_p",  cop_sel, 1'b1);
        check32("t2_addr_p", cop_addr, 32'h0000_0200);
        cop_ack = 1'b1; cop_data = 32'h2222_2222;
        @(negedge clk);
        check1 ("t2_pack",   py_ack, 1'b1);
        check32("t2_pres",   py_result, 32'h2222_2222);
        check32("t2_ldata2", logic_data, 32'h1111_1111);
        cop_ack = 1'b0; py_req = 1'b0;
        repeat (2) @(negedge clk);
        check32("t2_lcount", 32'(lack_cnt - l0), 32'd1);
        check32("t2_pcount", 32'(pack_cnt - p0), 32'd1);

        // Fairness with both requests held: L, P, L, P
        logic_addr = 32'h0000_00A0; py_code_addr = 32'h0000_00B0;
        logic_req = 1'b1; py_req = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_cop_req("fair_req");
            check1("fair_sel", cop_sel, 1'(i % 2));
            cop_ack = 1'b1; cop_data = 32'(i + 5);
            @(negedge clk);
            cop_ack = 1'b0;
            if (i % 2 == 0) begin
                check1 ("fair_lack", logic_ack, 1'b1);
                check32("fair_ldata", logic_data, 32'(i + 5));
                logic_req = 1'b0;
            end else begin
                check1 ("fair_pack", py_ack, 1'b1);
                check32("fair_pres", py_result, 32'(i + 5));
                py_req = 1'b0;
            end
            repeat (2) @(negedge clk);
            if (i < 3) begin
                logic_req = 1'b1; py_req = 1'b1;
            end else begin
                logic_req = 1'b0; py_req = 1'b0;
            end
        end
        idle_wait("fair_idle");

        // Timeout on a Python request
        check1("t4_err_pre", timeout_err, 1'b0);
        py_code_addr = 32'h0000_0300;
        py_req = 1'b1;
        cnt = 0; k = 0;
        do begin
            @(negedge clk);
            k++;
            if (cop_req) cnt++;
        end while (!py_ack && k < 30);
        check32("t4_req_cycles", 32'(cnt), 32'd8);
        check1 ("t4_pack",  py_ack, 1'b1);
        check32("t4_pres",  py_result, 32'hDEADBEEF);
        check1 ("t4_err",   timeout_err, 1'b1);
        check32("t4_count", {24'd0, timeout_count}, 32'd1);
        py_req = 1'b0;
        idle_wait("t4_idle");

        // Ack on the exact timeout edge wins
        py_req = 1'b1;
        repeat (8) @(negedge clk);
        check1("t5_req_last", cop_req, 1'b1);
        cop_ack = 1'b1; cop_data = 32'h5A5A_5A5A;
        @(negedge clk);
        cop_ack = 1'b0;
        check1 ("t5_pack",  py_ack, 1'b1);
        check32("t5_pres",  py_result, 32'h5A5A_5A5A);
        check32("t5_count", {24'd0, timeout_count}, 32'd1);
        check1 ("t5_err",   timeout_err, 1'b1);
        py_req = 1'b0;
        idle_wait("t5_idle");

        // Second timeout counts up; then err_clr coincident with a timeout; then a plain clear
        run_timeout("t6a", 1'b0);
        check32("t6a_count", {24'd0, timeout_count}, 32'd2);
        run_timeout("t6b", 1'b1);
        check1 ("t6b_err",   timeout_err, 1'b1);
        check32("t6b_count", {24'd0, timeout_count}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check1 ("t6c_err",   timeout_err, 1'b0);
        check32("t6c_count", {24'd0, timeout_count}, 32'd0);

        // Reset mid-ISSUE, then a fresh request
        logic_addr = 32'h0000_0500;
        logic_req = 1'b1;
        @(negedge clk);
        check1("t7_req", cop_req, 1'b1);
        l0 = lack_cnt;
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        cop_ack = 1'b1; cop_data = 32'h7777_7777;
        #1;
        check_zero("t7_async");
        repeat (2) @(negedge clk);
        check_zero("t7_hold");
        cop_ack = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check1 ("t7_noack",  logic_ack, 1'b0);
        check32("t7_lcount", 32'(lack_cnt - l0), 32'd0);
        check1 ("t7_req2",   cop_req, 1'b1);
        check1 ("t7_sel2",   cop_sel, 1'b0);
        check32("t7_addr2",  cop_addr, 32'h0000_0500);
        cop_ack = 1'b1; cop_data = 32'h1234_5678;
        @(negedge clk);
        cop_ack = 1'b0;
        check1 ("t7_lack",  logic_ack, 1'b1);
        check32("t7_ldata", logic_data, 32'h1234_5678);
        logic_req = 1'b0;
        idle_wait("t7_idle");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/thiele_coproc_arbiter.md
# thiele_coproc_arbiter

Shares a single external coprocessor port between the Thiele CPU's two blocking request channels: the logic-engine channel (`logic_req`/`logic_ack`) and the Python-execution channel (`py_req`/`py_ack`). It sits between `thiele_cpu` and the off-chip oracle. It serialises requests with round-robin fairness and enforces a response timeout. A stalled coprocessor produces an error word instead of hanging the CPU.

## Interface
- `TIMEOUT`, default 64: maximum cycles `cop_req` stays high awaiting `cop_ack`; legal range 2..65535.
- `ERR_DATA`, default 32'hDEADBEEF: data returned to the requester on timeout.
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `logic_req`  in  1  logic-engine request level from the CPU.
- `logic_addr`  in  32  logic-engine operand address.
- `logic_ack`  out  1  one-cycle completion pulse to the CPU.
- `logic_data`  out  32  logic-engine result; held until the next logic response.
- `py_req`  in  1  Python-execution request level.
- `py_code_addr`  in  32  Python code address.
- `py_ack`  out  1  one-cycle completion pulse.
- `py_result`  out  32  Python result; held until the next Python response.
- `cop_req`  out  1  shared coprocessor request.
- `cop_sel`  out  1  owner of the current request: 0 = logic, 1 = Python.
- `cop_addr`  out  32  address latched at grant.
- `cop_ack`  in  1  coprocessor completion; sampled only in ISSUE.
- `cop_data`  in  32  coprocessor result; valid with `cop_ack`.
- `busy`  out  1  high in every state except IDLE.
- `timeout_err`  out  1  sticky flag, set on any timeout.
- `timeout_count`  out  8  number of timeouts; saturates at 255.
- `err_clr`  in  1  synchronous clear of `timeout_err` and `timeout_count`.

## Operation
- States: IDLE, ISSUE, RESPOND, WAIT_DROP.
- **IDLE**
  - With any request high at an edge: choose the winner, set `cop_sel`, latch the winner's address into `cop_addr`, set `cop_req`=1, clear the timer, go to ISSUE.
  - Arbitration: with one request, it wins. With both, the requester not granted last wins. `last_grant` resets to Python, so logic wins the first tie.
- **ISSUE**
  - `cop_req` is held high and `cop_addr`/`cop_sel` are stable.
  - On `cop_ack`=1: `cop_req`<=0, copy `cop_data` into the owner's data output, pulse the owner's ack, go to RESPOND.
  - Timer: increments each ISSUE cycle. If no ack has arrived when it reaches TIMEOUT-1, the next edge is a timeout.
  - On timeout: drop `cop_req`, load `ERR_DATA` into the owner's data output, pulse the owner's ack, set `timeout_err`, increment `timeout_count` (saturating), go to RESPOND.
  - If `cop_ack` arrives on the timeout edge, the ack wins and no error is recorded.
- **RESPOND**
  - The owner's ack is high for exactly this one cycle.
  - Update `last_grant`.
  - Go to WAIT_DROP.
- **WAIT_DROP**
  - Wait until the owner's req is low, then go to IDLE.
  - This prevents a still-asserted request being re-granted.
  - The other requester's pending req is served from IDLE afterwards.
- **Ignored inputs**
  - `cop_ack` outside ISSUE is ignored.
  - A requester's address changing after grant is ignored.
  - A non-owner's req is never acked.
- **err_clr**
  - Clears `timeout_err` and `timeout_count` to 0.
  - If a timeout occurs on the same edge, the result is flag=1 and count=1.
- **Reset** (at any point, including mid-ISSUE)
  - All outputs go to 0: `cop_req`, `cop_sel`, `cop_addr`, both acks, both data outputs, `busy`, `timeout_err`, `timeout_count`.
  - State goes to IDLE and `last_grant` to Python.
  - No ack is produced for the aborted request.

## Timing
- All outputs are registered; there are no combinational input-to-output paths.
- Request sampled at edge E0: `cop_req` is high after E0.
- `cop_ack` sampled at edge Ek: after Ek, `cop_req` is low, data is valid and the ack is high for one cycle.
- Minimum request-to-ack latency: 2 edges, when `cop_ack` is high in the first ISSUE cycle.
- Timeout: `cop_req` is high for exactly TIMEOUT cycles, then the ack with `ERR_DATA` follows.
- Back-to-back service: after RESPOND there is at least 1 WAIT_DROP cycle and 1 IDLE cycle. The earliest next `cop_req` rises 3 edges after the ack pulse.
- Data outputs update only on the owner's ack edge.

## Test plan
- **Logic only:** `logic_req`=1, `logic_addr`=0x40, `cop_ack` 3 cycles after `cop_req` with `cop_data`=0xABCD1234.
  - Required: `cop_sel`=0, `cop_addr`=0x40, a single `logic_ack` pulse, `logic_data`=0xABCD1234, `py_ack` stays 0.
- **Simultaneous requests out of reset:**
  - Required: logic is served first, then Python with `cop_sel`=1 and `cop_addr`=`py_code_addr`.
  - Both served exactly once, in that order.
- **Fairness:** hold both reqs continuously (each re-raised after its ack).
  - Required: grants alternate L, P, L, P.
- **Timeout:** TIMEOUT=8, Python request, `cop_ack` never asserted.
  - Required: `cop_req` high for exactly 8 cycles, `py_result`=0xDEADBEEF, `timeout_err`=1, `timeout_count`=1.
  - Then `cop_ack` on the exact timeout edge: normal data returned, `timeout_count` still 1.
- **err_clr:** pulse `err_clr`, including a pulse coincident with a timeout edge.
  - Required: flag=0/count=0 after a plain clear; flag=1/count=1 when coincident with a timeout.
- **Reset mid-ISSUE:** deassert `rst_n` while `cop_req`=1.
  - Required: all outputs 0 immediately (asynchronously), no ack issued, and a fresh request is served normally after release.
